// File: rtl/fpga_bridge_rcv_32.sv
// FPGA-side receiver of the 32-bit chip-to-FPGA bridge link.
// Rebuilds 64-bit flits per channel, buffers them and returns credits.

module fpga_bridge_rcv_32_chan #(
  parameter int BUF_DEPTH = 4,
  parameter int BUF_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        word_vld,
  input  logic [31:0] word,
  output logic [63:0] bout_data,
  output logic        bout_val,
  input  logic        bout_rdy,
  output logic        credit,
  output logic        overflow
);

  localparam logic [BUF_AW:0] FULL_CNT = (BUF_AW+1)'(BUF_DEPTH);

  logic              half_q, half_d;
  logic [31:0]       hold_q, hold_d;
  logic [63:0]       mem_q [BUF_DEPTH];
  logic [63:0]       mem_d [BUF_DEPTH];
  logic [BUF_AW-1:0] wptr_q, wptr_d;
  logic [BUF_AW-1:0] rptr_q, rptr_d;
  logic [BUF_AW:0]   cnt_q, cnt_d;
  logic              credit_q, credit_d;
  logic              err_q, err_d;

  logic full;
  logic pop;
  logic wr;
  logic wr_ok;

  // Handshake and write qualification; a pop frees room for a same-cycle write.
  always_comb begin
    full  = (cnt_q == FULL_CNT);
    pop   = (cnt_q != '0) && bout_rdy;
    wr    = word_vld && half_q;
    wr_ok = wr && (!full || pop);
  end

  // Half-word framing: first word is held, second completes the flit.
  always_comb begin
    half_d = half_q;
    hold_d = hold_q;
    if (word_vld) begin
      if (!half_q) begin
        hold_d = word;
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
      end
    end
  end

  // Circular flit buffer with occupancy count.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_ok) begin
      mem_d[wptr_q] = {hold_q, word};
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({wr_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // One credit per dequeued flit; sticky flag when a flit had to be dropped.
  always_comb begin
    credit_d = pop;
    err_d    = err_q | (wr && !wr_ok);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q   <= 1'b0;
      hold_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      half_q   <= half_d;
      hold_q   <= hold_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bout_val  = (cnt_q != '0);
  assign bout_data = mem_q[rptr_q];
  assign credit    = credit_q;
  assign overflow  = err_q;

endmodule

module fpga_bridge_rcv_32 #(
  parameter int BUF_DEPTH = 4,
  parameter int BUF_AW    = 2
) (
  input  logic        intcnct_clk,
  input  logic        rst,
  input  logic [31:0] data_from_chip,
  input  logic [1:0]  channel_from_chip,
  output logic [2:0]  credit_to_chip,
  output logic [63:0] bout_data_1,
  output logic        bout_val_1,
  input  logic        bout_rdy_1,
  output logic [63:0] bout_data_2,
  output logic        bout_val_2,
  input  logic        bout_rdy_2,
  output logic [63:0] bout_data_3,
  output logic        bout_val_3,
  input  logic        bout_rdy_3,
  output logic [2:0]  overflow_err
);

  logic [2:0] word_vld;

  // Channel decode; channel 0 is idle and selects nothing.
  always_comb begin
    word_vld    = '0;
    word_vld[0] = (channel_from_chip == 2'd1);
    word_vld[1] = (channel_from_chip == 2'd2);
    word_vld[2] = (channel_from_chip == 2'd3);
  end

  fpga_bridge_rcv_32_chan #(
    .BUF_DEPTH (BUF_DEPTH),
    .BUF_AW    (BUF_AW)
  ) u_ch1 (
    .clk       (intcnct_clk),
    .rst       (rst),
    .word_vld  (word_vld[0]),
    .word      (data_from_chip),
    .bout_data (bout_data_1),
    .bout_val  (bout_val_1),
    .bout_rdy  (bout_rdy_1),
    .credit    (credit_to_chip[0]),
    .overflow  (overflow_err[0])
  );

  fpga_bridge_rcv_32_chan #(
    .BUF_DEPTH (BUF_DEPTH),
    .BUF_AW    (BUF_AW)
  ) u_ch2 (
    .clk       (intcnct_clk),
    .rst       (rst),
    .word_vld  (word_vld[1]),
    .word      (data_from_chip),
    .bout_data (bout_data_2),
    .bout_val  (bout_val_2),
    .bout_rdy  (bout_rdy_2),
    .credit    (credit_to_chip[1]),
    .overflow  (overflow_err[1])
  );

  fpga_bridge_rcv_32_chan #(
    .BUF_DEPTH (BUF_DEPTH),
    .BUF_AW    (BUF_AW)
  ) u_ch3 (
    .clk       (intcnct_clk),
    .rst       (rst),
    .word_vld  (word_vld[2]),
    .word      (data_from_chip),
    .bout_data (bout_data_3),
    .bout_val  (bout_val_3),
    .bout_rdy  (bout_rdy_3),
    .credit    (credit_to_chip[2]),
    .overflow  (overflow_err[2])
  );

endmodule

// File: tb/tb_fpga_bridge_rcv_32.sv
// Bench for fpga_bridge_rcv_32: per-channel flit queues model,
// stimulus pushes expectations, a forked monitor pops and compares.

module tb_fpga_bridge_rcv_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [1:0]  chin;
  logic [2:0]  credit;
  logic [2:0]  err;
  logic [2:0]  rdy;
  logic [63:0] d1, d2, d3;
  logic        v1, v2, v3;
  logic [2:0]  val;

  assign val = {v3, v2, v1};

  fpga_bridge_rcv_32 dut (
    .intcnct_clk       (clk),
    .rst               (rst),
    .data_from_chip    (din),
    .channel_from_chip (chin),
    .credit_to_chip    (credit),
    .bout_data_1       (d1),
    .bout_val_1        (v1),
    .bout_rdy_1        (rdy[0]),
    .bout_data_2       (d2),
    .bout_val_2        (v2),
    .bout_rdy_2        (rdy[1]),
    .bout_data_3       (d3),
    .bout_val_3        (v3),
    .bout_rdy_3        (rdy[2]),
    .overflow_err      (err)
  );

  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [63:0] expq [3][$];
  logic [31:0] holdw [3];
  bit          pend [3];
  logic [2:0]  exp_err;
  logic [2:0]  prev_hs;
  int          pops [3];
  int          creds [3];
  int          sent [3];

  function automatic logic [63:0] dout(int c);
    case (c)
      0:       return d1;
      1:       return d2;
      default: return d3;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [2:0] hs;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hs = '0;
        for (int c = 0; c < 3; c++) begin
          expq[c].delete();
          pops[c]  = 0;
          creds[c] = 0;
        end
      end else begin
        chk("credit", {61'd0, credit}, {61'd0, prev_hs});
        hs = val & rdy;
        for (int c = 0; c < 3; c++) begin
          creds[c] += int'(credit[c]);
          if (hs[c]) begin
            pops[c]++;
            if (expq[c].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_flit_ch%0d: got %h expected none",
                       c + 1, dout(c));
            end else begin
              chk($sformatf("data_ch%0d", c + 1), dout(c),
                  expq[c].pop_front());
            end
          end
        end
        prev_hs = hs;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  // Model: a completing word makes a flit; it is kept unless the buffer
  // is full and nothing leaves in that same cycle.
  task automatic send(int ch, logic [31:0] w);
    int c;
    c    = ch - 1;
    chin = 2'(ch);
    din  = w;
    if (!pend[c]) begin
      pend[c]  = 1'b1;
      holdw[c] = w;
    end else begin
      pend[c] = 1'b0;
      if (expq[c].size() == 4 && !rdy[c]) exp_err[c] = 1'b1;
      else expq[c].push_back({holdw[c], w});
    end
    step();
    chin = 2'd0;
    din  = $urandom;
  endtask

  task automatic send_flit(int ch, logic [63:0] f);
    send(ch, f[63:32]);
    send(ch, f[31:0]);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drain();
    int n;
    rdy = 3'b111;
    n   = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0
           && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d left expected 0",
               expq[0].size() + expq[1].size() + expq[2].size());
    end
    idle(3);
  endtask

  task automatic clear_model();
    for (int c = 0; c < 3; c++) begin
      pend[c] = 1'b0;
      sent[c] = 0;
    end
    exp_err = '0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    chin = 2'd0;
    idle(2);
    clear_model();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] f;
    int          c0;
    int          ch;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    rdy     = '0;
    chin    = '0;
    din     = '0;
    prev_hs = '0;
    clear_model();
    fork
      monitor();
    join_none
    idle(2);
    chk("rst_val", {61'd0, val}, 64'd0);
    chk("rst_credit", {61'd0, credit}, 64'd0);
    chk("rst_err", {61'd0, err}, 64'd0);
    chk("rst_data1", d1, 64'd0);
    rst = 1'b0;
    step();

    // Basic flit on channel 1.
    rdy = 3'b001;
    send(1, 32'hAAAA0001);
    send(1, 32'h55550002);
    chk("t1_val", {63'd0, v1}, 64'd1);
    chk("t1_data", d1, 64'hAAAA0001_55550002);
    step();
    chk("t1_credit", {61'd0, credit}, 64'd1);
    idle(2);

    // Interleaved halves on channels 2 and 3.
    rdy = 3'b000;
    send(2, 32'h2222_0001);
    send(3, 32'h3333_0001);
    idle(1);
    send(3, 32'h3333_0002);
    chk("t2_order", {62'd0, v3, v2}, 64'd2);
    send(2, 32'h2222_0002);
    chk("t2_both", {62'd0, v3, v2}, 64'd3);
    drain();

    // Back-pressure on channel 2.
    rdy = 3'b000;
    for (int i = 0; i < 4; i++) send_flit(2, rnd64());
    chk("t3_val", {63'd0, v2}, 64'd1);
    idle(5);
    chk("t3_head", d2, expq[1][0]);
    c0 = creds[1];
    drain();
    chk("t3_credits", 64'(creds[1] - c0), 64'd4);

    // Overflow on channel 1, then a legal write-while-full.
    rdy = 3'b000;
    for (int i = 0; i < 5; i++) send_flit(1, rnd64());
    idle(1);
    chk("t4_err", {61'd0, err}, 64'd1);
    chk("t4_model_err", {61'd0, err}, {61'd0, exp_err});
    drain();
    do_reset();
    rdy = 3'b000;
    for (int i = 0; i < 4; i++) send_flit(1, rnd64());
    f = rnd64();
    send(1, f[63:32]);
    rdy = 3'b001;
    send(1, f[31:0]);
    rdy = 3'b000;
    idle(1);
    chk("t4_noerr", {61'd0, err}, 64'd0);
    drain();

    // Reset with a pending half and buffered flits.
    rdy = 3'b000;
    send_flit(3, rnd64());
    send_flit(3, rnd64());
    send(3, 32'hDEAD_BEEF);
    rst = 1'b1;
    #2;
    chk("t5_val", {61'd0, val}, 64'd0);
    chk("t5_credit", {61'd0, credit}, 64'd0);
    chk("t5_err", {61'd0, err}, 64'd0);
    step();
    clear_model();
    rst = 1'b0;
    step();
    rdy = 3'b100;
    send(3, 32'h0123_4567);
    send(3, 32'h89AB_CDEF);
    chk("t5_fresh", d3, 64'h0123_4567_89AB_CDEF);
    drain();

    // Random traffic from a credit-respecting sender.
    for (int i = 0; i < 3000; i++) begin
      rdy = 3'($urandom);
      ch  = int'($urandom_range(0, 3));
      if (ch != 0 && pend[ch-1]) begin
        send(ch, $urandom);
      end else if (ch != 0 && (sent[ch-1] - creds[ch-1]) < 4) begin
        sent[ch-1]++;
        send(ch, $urandom);
      end else begin
        step();
      end
    end
    for (int c = 0; c < 3; c++) begin
      if (pend[c]) send(c + 1, $urandom);
    end
    drain();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("credits_ch%0d", c + 1), 64'(creds[c]), 64'(pops[c]));
    end
    chk("t6_err", {61'd0, err}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
